// File: rtl/ofdm_frame_streamer_pkg.sv
// Shared definitions for the OFDM frame streamer.
//   - state_e   : streamer FSM states
//   - DW_DEF    : default bits per I or Q sample
//   - AW_DEF    : default sample RAM address width
//   - OFDM_PACK_IQ(q, i) : packs a {Q,I} sample word, same layout as the RX chain

package ofdm_frame_streamer_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREF   = 3'd1,
    ST_BURST  = 3'd2,
    ST_WAITDN = 3'd3,
    ST_GAP    = 3'd4
  } state_e;

endpackage

`ifndef OFDM_PACK_IQ
`define OFDM_PACK_IQ(q, i) {(q), (i)}
`endif

// File: rtl/ofdm_frame_streamer_if.sv
// Sample bus between the frame streamer and the OFDM receiver.
//   cyc  : bus cycle, high for a whole frame
//   stb  : sample valid
//   ack  : sink accepts the sample when stb & ack
//   q_ch : Q sample
//   i_ch : I sample
// master modport = streamer, slave modport = receiver.

interface ofdm_frame_streamer_if
  import ofdm_frame_streamer_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic          cyc;
  logic          stb;
  logic          ack;
  logic [DW-1:0] q_ch;
  logic [DW-1:0] i_ch;

  modport master (output cyc, output stb, output q_ch, output i_ch, input ack);
  modport slave  (input cyc, input stb, input q_ch, input i_ch, output ack);
endinterface

// File: rtl/ofdm_frame_streamer_ram.sv
// Sample RAM for the frame streamer: 2**AW words of 2*DW bits, one write
// port and one read port with a single cycle of read latency. No reset on
// the array or read register so it maps onto block RAM.
//   clk : clock
//   we  : write strobe
//   wa  : write address
//   wd  : write data {Q,I}
//   ra  : read address
//   rd  : read data, valid the cycle after ra

module ofdm_frame_streamer_ram #(
  parameter int DW = 16,
  parameter int AW = 15
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [2*DW-1:0] wd,
  input  logic [AW-1:0]   ra,
  output logic [2*DW-1:0] rd
);

  logic [2*DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end

endmodule

// File: rtl/ofdm_frame_streamer.sv
// Frame source for the OFDM RX chain. Replays samples held in an internal
// RAM as nfrm frames of flen samples over the cyc/stb/ack bus, with a
// programmable idle gap between frames.
// Optional build macro FRM_STREAM_WAIT_DONE_EN: after each frame the
// streamer also waits for a receiver end-of-frame pulse on done.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   ld_we/ld_adr/ld_dat : sample RAM load port (ignored while busy)
//   start       : start pulse; flen/nfrm/gap sampled with it
//   abort       : stop streaming at the next edge
//   flen        : samples per frame (0 ignores start)
//   nfrm        : frames to send (0 = until abort)
//   gap         : idle cycles between frames (min 1)
//   done        : receiver end-of-frame pulse
//   bus         : sample bus, master side
//   busy        : streamer not idle
//   frm_cnt     : frames completed since start (wraps)
//
// state  | meaning
// IDLE   | waiting for start, RAM loads accepted
// PREF   | first RAM read of the run in flight
// BURST  | frame in progress, stb high
// WAITDN | frame sent, waiting for done
// GAP    | inter-frame idle, next sample already prefetched

module ofdm_frame_streamer
  import ofdm_frame_streamer_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int FLEN_W = 16,
  parameter int NFRM_W = 8,
  parameter int GAP_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_we,
  input  logic [AW-1:0]        ld_adr,
  input  logic [2*DW-1:0]      ld_dat,
  input  logic                 start,
  input  logic                 abort,
  input  logic [FLEN_W-1:0]    flen,
  input  logic [NFRM_W-1:0]    nfrm,
  input  logic [GAP_W-1:0]     gap,
  input  logic                 done,
  ofdm_frame_streamer_if.master bus,
  output logic                 busy,
  output logic [NFRM_W-1:0]    frm_cnt
);

  state_e              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [FLEN_W-1:0]   idx_q, idx_d;
  logic [NFRM_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [FLEN_W-1:0]   flen_q;
  logic [NFRM_W-1:0]   nfrm_q;
  logic [GAP_W-1:0]    gap_q;
  logic [GAP_W-1:0]    gap_len;
  logic                start_ok;
  logic [2*DW-1:0]     ram_q;

`ifndef FRM_STREAM_WAIT_DONE_EN
  logic unused_done;
  assign unused_done = done;
`endif

  assign gap_len = (gap_q == '0) ? GAP_W'(1) : gap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      gap_cnt_q <= '0;
      flen_q    <= '0;
      nfrm_q    <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      gap_cnt_q <= gap_cnt_d;
      if (start_ok) begin
        flen_q <= flen;
        nfrm_q <= nfrm;
        gap_q  <= gap;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    gap_cnt_d = gap_cnt_q;
    start_ok  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && flen != '0 && !abort) begin
          start_ok = 1'b1;
          state_d  = ST_PREF;
          addr_d   = '0;
          idx_d    = '0;
          cnt_d    = '0;
        end
      end
      ST_PREF: state_d = ST_BURST;
      ST_BURST: begin
        if (bus.ack) begin
          addr_d = addr_q + AW'(1);
          if (idx_q == flen_q - FLEN_W'(1)) begin
            idx_d     = '0;
            cnt_d     = cnt_q + NFRM_W'(1);
            gap_cnt_d = gap_len - GAP_W'(1);
`ifdef FRM_STREAM_WAIT_DONE_EN
            state_d   = ST_WAITDN;
`else
            state_d   = ST_GAP;
`endif
          end else begin
            idx_d = idx_q + FLEN_W'(1);
          end
        end
      end
      ST_WAITDN: begin
`ifdef FRM_STREAM_WAIT_DONE_EN
        if (done) state_d = ST_GAP;
`else
        state_d = ST_GAP;
`endif
      end
      ST_GAP: begin
        // RAM already reads addr_q here, so the next frame goes straight
        // to BURST and the gap length is exactly gap_len low cycles.
        if (gap_cnt_q == '0) begin
          if (nfrm_q != '0 && cnt_q == nfrm_q) state_d = ST_IDLE;
          else                                 state_d = ST_BURST;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort beats a same-cycle ack: position and frame count are frozen.
    if (abort) begin
      state_d = ST_IDLE;
      addr_d  = addr_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
    end
  end

  ofdm_frame_streamer_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk (clk),
    .we  (ld_we && state_q == ST_IDLE),
    .wa  (ld_adr),
    .wd  (ld_dat),
    .ra  (addr_d),
    .rd  (ram_q)
  );

  assign bus.cyc  = (state_q == ST_BURST);
  assign bus.stb  = (state_q == ST_BURST);
  assign bus.q_ch = bus.stb ? ram_q[2*DW-1:DW] : '0;
  assign bus.i_ch = bus.stb ? ram_q[DW-1:0]    : '0;
  assign busy     = (state_q != ST_IDLE);
  assign frm_cnt  = cnt_q;

endmodule
